// File: rtl/dot_arbiter.sv
// dot_arbiter: shares one dot-product unit between N_REQ requesters.
// An issue FSM round-robin grants a non-empty requester, latches its x/y pair for the dot unit,
// and records the requester index as a tag. Results come back in issue order and are routed to
// the requester named by the oldest tag.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   req_x/req_y         per-requester operand vectors (head of each requester FIFO)
//   req_empty/req_rd_en per-requester FIFO empty / pop strobe (one-hot or zero)
//   dot_x/dot_y         operand pair presented to the dot unit
//   dot_in_empty        low while dot_x/dot_y hold a valid pair
//   dot_in_rd_en        dot unit consumes the pair
//   dot_out/_empty/_rd_en  first-word-fall-through dot result FIFO interface
//   res_dout            shared result bus, 0 when nothing is written
//   res_full/res_wr_en  per-requester result FIFO full / write strobe (one-hot or zero)
//   inflight            tags issued but not yet returned
module dot_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned TAG_DEPTH = 16,
  parameter int unsigned TAG_W     = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic signed [N_REQ-1:0][2:0][31:0] req_x,
  input  logic signed [N_REQ-1:0][2:0][31:0] req_y,
  input  logic [N_REQ-1:0]                  req_empty,
  output logic [N_REQ-1:0]                  req_rd_en,
  output logic signed [2:0][31:0]           dot_x,
  output logic signed [2:0][31:0]           dot_y,
  output logic                              dot_in_empty,
  input  logic                              dot_in_rd_en,
  input  logic signed [31:0]                dot_out,
  input  logic                              dot_out_empty,
  output logic                              dot_out_rd_en,
  output logic signed [31:0]                res_dout,
  input  logic [N_REQ-1:0]                  res_full,
  output logic [N_REQ-1:0]                  res_wr_en,
  output logic [$clog2(TAG_DEPTH):0]        inflight
);

  localparam int unsigned AW = $clog2(TAG_DEPTH);
  localparam int unsigned PW = $clog2(N_REQ);

  typedef enum logic [0:0] {StArb, StHold} state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_nxt;
  logic [PW-1:0]          gnt_idx, idx;
  logic                   gnt_valid;
  logic                   push, pop, head_full;
  logic                   tag_full, tag_empty;
  logic [TAG_W-1:0]       tag_mem [TAG_DEPTH];
  logic [TAG_W-1:0]       tag_head;
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q;
  logic signed [2:0][31:0] x_q, y_q;

  assign tag_full     = (count_q == (AW+1)'(TAG_DEPTH));
  assign tag_empty    = (count_q == '0);
  assign tag_head     = tag_mem[rd_ptr_q];
  assign inflight     = count_q;
  assign dot_x        = x_q;
  assign dot_y        = y_q;
  assign dot_in_empty = (state_q == StArb);
  assign rr_ptr_nxt   = PW'((int'(gnt_idx) + 1) % N_REQ);

  // Round-robin search: first non-empty requester at or after rr_ptr.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(rr_ptr_q) + k) % N_REQ);
      if (!gnt_valid && !req_empty[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  // Issue FSM; strobes are forced low while reset is asserted.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    req_rd_en = '0;
    unique case (state_q)
      StArb: begin
        if (gnt_valid && !tag_full && !reset) begin
          push               = 1'b1;
          req_rd_en[gnt_idx] = 1'b1;
          state_d            = StHold;
        end
      end
      StHold: begin
        if (dot_in_rd_en) state_d = StArb;
      end
      default: state_d = StArb;
    endcase
  end

  // Return path: route the result to the oldest tag's requester unless its FIFO is full.
  // A result with no tag outstanding is left in the dot FIFO untouched.
  always_comb begin
    head_full = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (tag_head == TAG_W'(i)) head_full = res_full[i];
    end
    pop       = !dot_out_empty && !tag_empty && !head_full && !reset;
    res_wr_en = '0;
    for (int i = 0; i < N_REQ; i++) begin
      res_wr_en[i] = pop && (tag_head == TAG_W'(i));
    end
    dot_out_rd_en = pop;
    res_dout      = pop ? dot_out : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StArb;
      rr_ptr_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        rr_ptr_q <= rr_ptr_nxt;
        x_q      <= req_x[gnt_idx];
        y_q      <= req_y[gnt_idx];
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Tag storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (push) tag_mem[wr_ptr_q] <= TAG_W'(gnt_idx);
  end

endmodule

// File: tb/tb_dot_arbiter.sv
// tb_dot_arbiter: directed bench for dot_arbiter (N_REQ=4, TAG_DEPTH=16).
// Inputs change just after each falling edge; outputs are sampled 1 time unit later.
module tb_dot_arbiter;

  logic                         clock;
  logic                         reset;
  logic signed [3:0][2:0][31:0] req_x, req_y;
  logic [3:0]                   req_empty;
  logic [3:0]                   req_rd_en;
  logic signed [2:0][31:0]      dot_x, dot_y;
  logic                         dot_in_empty;
  logic                         dot_in_rd_en;
  logic signed [31:0]           dot_out;
  logic                         dot_out_empty;
  logic                         dot_out_rd_en;
  logic signed [31:0]           res_dout;
  logic [3:0]                   res_full;
  logic [3:0]                   res_wr_en;
  logic [4:0]                   inflight;

  int n_checks = 0;
  int n_pass   = 0;

  dot_arbiter #(.N_REQ(4), .TAG_DEPTH(16), .TAG_W(3)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_empty     (req_empty),
    .req_rd_en     (req_rd_en),
    .dot_x         (dot_x),
    .dot_y         (dot_y),
    .dot_in_empty  (dot_in_empty),
    .dot_in_rd_en  (dot_in_rd_en),
    .dot_out       (dot_out),
    .dot_out_empty (dot_out_empty),
    .dot_out_rd_en (dot_out_rd_en),
    .res_dout      (res_dout),
    .res_full      (res_full),
    .res_wr_en     (res_wr_en),
    .inflight      (inflight)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One full issue: grant in ARB, then consume the pair in HOLD.
  task automatic do_grant(input logic [3:0] exp);
    dot_in_rd_en = 1'b0;
    #1 check("grant", req_rd_en, exp);
    @(negedge clock);
    dot_in_rd_en = 1'b1;
    #1 check("hold_valid", dot_in_empty, 1'b0);
    @(negedge clock);
    dot_in_rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_empty = '1; dot_in_rd_en = 1'b0; dot_out = '0;
    dot_out_empty = 1'b1; res_full = '0; req_x = '0; req_y = '0;

    // Reset state, strobes held low during reset even with requests pending
    @(negedge clock);
    req_empty = '0;
    #1;
    check("rst_dot_in_empty", dot_in_empty, 1'b1);
    check("rst_inflight", inflight, 0);
    check("rst_req_rd_en", req_rd_en, 0);
    check("rst_res_wr_en", res_wr_en, 0);
    check("rst_dot_out_rd_en", dot_out_rd_en, 0);
    check("rst_res_dout", res_dout, 0);
    check("rst_dot_x", dot_x, 0);
    req_empty = '1;
    @(negedge clock);
    reset = 1'b0;

    // Single request from requester 2, Q10 operands
    req_x[2][0] = 1024; req_x[2][1] = 2048; req_x[2][2] = 0;
    req_y[2][0] = 1024; req_y[2][1] = 1024; req_y[2][2] = 0;
    req_empty = 4'b1011;
    #1 check("single_grant", req_rd_en, 4'b0100);
    @(negedge clock);
    req_empty = '1;
    #1;
    check("single_valid", dot_in_empty, 1'b0);
    check("single_x0", dot_x[0], 1024);
    check("single_x1", dot_x[1], 2048);
    check("single_y1", dot_y[1], 1024);
    check("single_inflight", inflight, 1);
    check("single_no_regrant", req_rd_en, 0);
    @(negedge clock);
    #1 check("single_held", dot_in_empty, 1'b0);
    check("single_x0_held", dot_x[0], 1024);
    dot_in_rd_en = 1'b1;
    @(negedge clock);
    dot_in_rd_en = 1'b0; dot_out = 3072; dot_out_empty = 1'b0;
    #1;
    check("single_back_arb", dot_in_empty, 1'b1);
    check("single_out_rd", dot_out_rd_en, 1'b1);
    check("single_wr_en", res_wr_en, 4'b0100);
    check("single_dout", res_dout, 3072);
    @(negedge clock);
    dot_out_empty = 1'b1;
    #1;
    check("single_inflight0", inflight, 0);
    check("idle_dout", res_dout, 0);

    // Round robin with all requesters busy
    do_reset();
    req_empty = '0;
    for (int g = 0; g < 8; g++) do_grant(4'b0001 << (g % 4));
    #1 check("rr_inflight", inflight, 8);

    // Tag FIFO full blocks the 17th grant; a return frees a slot
    do_reset();
    req_empty = '0;
    for (int g = 0; g < 16; g++) do_grant(4'b0001 << (g % 4));
    #1;
    check("full_inflight", inflight, 16);
    check("full_no_grant", req_rd_en, 0);
    @(negedge clock);
    #1 check("full_no_grant2", req_rd_en, 0);
    dot_out = 7; dot_out_empty = 1'b0;
    #1;
    check("full_pop", dot_out_rd_en, 1'b1);
    check("full_wr_en", res_wr_en, 4'b0001);
    check("full_still_no_grant", req_rd_en, 0);
    @(negedge clock);
    dot_out_empty = 1'b1;
    #1;
    check("full_inflight15", inflight, 15);
    check("full_resume", req_rd_en, 4'b0001);
    @(negedge clock);
    dot_in_rd_en = 1'b1;
    @(negedge clock);
    dot_in_rd_en = 1'b0;

    // Result FIFO full for the head tag stalls return but not issue
    do_reset();
    req_empty = '0;
    do_grant(4'b0001);
    do_grant(4'b0010);
    req_empty = '1; dot_out = 100; dot_out_empty = 1'b0;
    #1 check("stall_pre_wr", res_wr_en, 4'b0001);
    @(negedge clock);
    res_full = 4'b0010; req_empty = 4'b1011;
    #1;
    check("stall_no_pop", dot_out_rd_en, 1'b0);
    check("stall_no_wr", res_wr_en, 0);
    check("stall_dout0", res_dout, 0);
    check("stall_inflight", inflight, 1);
    check("stall_issue", req_rd_en, 4'b0100);
    @(negedge clock);
    req_empty = '1; dot_in_rd_en = 1'b1;
    #1;
    check("stall_still", dot_out_rd_en, 1'b0);
    check("stall_inflight2", inflight, 2);
    @(negedge clock);
    dot_in_rd_en = 1'b0; res_full = '0; dot_out = 200;
    #1;
    check("stall_release_wr", res_wr_en, 4'b0010);
    check("stall_release_dout", res_dout, 200);
    @(negedge clock);

    // Same-cycle issue (requester 3) and return (tag 2)
    dot_out = 300; req_empty = 4'b0111;
    #1;
    check("both_grant", req_rd_en, 4'b1000);
    check("both_wr_en", res_wr_en, 4'b0100);
    check("both_pop", dot_out_rd_en, 1'b1);
    @(negedge clock);
    req_empty = '1; dot_out_empty = 1'b1;
    #1;
    check("both_inflight", inflight, 1);
    check("both_hold", dot_in_empty, 1'b0);
    dot_in_rd_en = 1'b1;
    @(negedge clock);
    dot_in_rd_en = 1'b0;

    // Reset while holding with 3 tags in flight
    do_reset();
    req_empty = '0;
    do_grant(4'b0001);
    do_grant(4'b0010);
    #1 check("mid_grant3", req_rd_en, 4'b0100);
    @(negedge clock);
    #1;
    check("mid_inflight3", inflight, 3);
    check("mid_hold", dot_in_empty, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_empty", dot_in_empty, 1'b1);
    check("mid_rst_inflight", inflight, 0);
    check("mid_rst_rd_en", req_rd_en, 0);
    check("mid_rst_dot_x", dot_x, 0);
    @(negedge clock);
    reset = 1'b0;
    #1 check("mid_rr_ptr0", req_rd_en, 4'b0001);
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dot_arbiter.md
DOT_ARBITER -- requirements
Module: dot_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one dot unit; legal range 2..8.
REQ-002 Parameter TAG_DEPTH, default 16: in-flight tag FIFO depth, power of two.
REQ-003 Parameter TAG_W, default 3: tag width; TAG_W >= ceil(log2(N_REQ)).
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_x  input  N_REQ x 3 x 32 signed  per-requester vector x operand (head of requester FIFO).
REQ-007 req_y  input  N_REQ x 3 x 32 signed  per-requester vector y operand.
REQ-008 req_empty  input  N_REQ  per-requester FIFO empty.
REQ-009 req_rd_en  output  N_REQ  per-requester pop strobe; one-hot or zero.
REQ-010 dot_x, dot_y  output  3 x 32 signed each  operands to shared dot unit.
REQ-011 dot_in_empty  output  1  low when dot_x/dot_y hold a valid pair.
REQ-012 dot_in_rd_en  input  1  dot unit consumes the pair this cycle.
REQ-013 dot_out  input  32 signed  dot result, first-word-fall-through.
REQ-014 dot_out_empty  input  1  dot result FIFO empty.
REQ-015 dot_out_rd_en  output  1  pop dot result.
REQ-016 res_dout  output  32 signed  result routed to requesters (shared bus).
REQ-017 res_full  input  N_REQ  per-requester result FIFO full.
REQ-018 res_wr_en  output  N_REQ  per-requester result write strobe; one-hot or zero.
REQ-019 inflight  output  $clog2(TAG_DEPTH)+1  number of tags issued but not yet returned.

Function
REQ-020 Issue FSM SHALL have states ARB and HOLD.
REQ-021 In ARB, the grant SHALL be the first requester i with req_empty[i]=0, searched round-robin starting at rr_ptr.
REQ-022 Grant in ARB SHALL occur only when tag FIFO not full; else remain in ARB, no req_rd_en.
REQ-023 On grant: req_rd_en[i]=1 for one cycle, req_x[i]/req_y[i] registered into dot_x/dot_y, tag i pushed into tag FIFO, rr_ptr <= (i+1) mod N_REQ, next state HOLD.
REQ-024 In HOLD, dot_in_empty SHALL be 0; on dot_in_rd_en=1 return to ARB next cycle; otherwise stay in HOLD with operands stable.
REQ-025 In ARB, dot_in_empty SHALL be 1; dot_in_rd_en in ARB SHALL be ignored.
REQ-026 Issue throughput: at most one pair per 2 cycles; grant-to-dot_in_empty-low latency 1 cycle.
REQ-027 Return path (combinational): when dot_out_empty=0, tag FIFO not empty and res_full[tag_head]=0 -> dot_out_rd_en=1, res_wr_en[tag_head]=1, tag pop, res_dout=dot_out.
REQ-028 When res_full[tag_head]=1, return path SHALL stall (no pop) without blocking issue.
REQ-029 Results SHALL return in issue order; dot unit is in-order.
REQ-030 Simultaneous tag push and pop SHALL leave inflight unchanged; push-only +1, pop-only -1.
REQ-031 res_dout SHALL be 0 when no res_wr_en asserted.
REQ-032 dot_out_empty=0 with tag FIFO empty is a protocol error: no pop, no write.

Reset
REQ-033 On reset: state ARB, rr_ptr 0, tag FIFO empty, inflight 0, dot_x/dot_y 0, dot_in_empty 1, all strobes 0.
REQ-034 Reset mid-operation SHALL discard held operand and all tags; no strobe asserted during reset.

Verification
REQ-035 Single request: req 2 pushes x=(1024,2048,0), y=(1024,1024,0) (Q10) -> one req_rd_en[2], dot pair held until dot_in_rd_en, result 3072 written with res_wr_en[2].
REQ-036 All 4 requesters non-empty continuously -> grants 0,1,2,3,0,... ; no requester granted twice before others.
REQ-037 Tag FIFO full: stall dot_out for 16 issues -> no 17th grant; inflight=16; release -> grants resume.
REQ-038 res_full[1]=1 with result for tag 1 at head -> no dot_out_rd_en; deassert -> written next cycle to requester 1 only.
REQ-039 Same-cycle issue and return -> inflight unchanged, both strobes correct.
REQ-040 Assert reset while in HOLD with 3 in flight -> next cycle dot_in_empty=1, inflight=0, rr_ptr=0.
